// File: rtl/mem_boot_loader_pkg.sv
// Shared constants for the memory boot loader: FSM encoding, size defaults,
// byte order and the header-length decode helper.
package boot_loader_pkg;

    localparam int unsigned ADDR_W_DEF    = 7;
    localparam int unsigned DEPTH_DEF     = 128;
    localparam int unsigned BASE_ADDR_DEF = 0;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned ST_W          = 3;

    // First stream byte lands in the most significant byte of the word
    localparam bit MSB_FIRST = 1'b1;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_LEN     = 3'd1;
    localparam logic [ST_W-1:0] ST_COLLECT = 3'd2;
    localparam logic [ST_W-1:0] ST_WRITE   = 3'd3;
    localparam logic [ST_W-1:0] ST_CHK     = 3'd4;
    localparam logic [ST_W-1:0] ST_FIN     = 3'd5;
    localparam logic [ST_W-1:0] ST_FAIL    = 3'd6;

    // Header byte to word count: 0 means a full image, oversize clamps to depth
    function automatic int unsigned words_from_len(input logic [BYTE_W-1:0] n,
                                                   input int unsigned depth);
        if (n == '0 || 32'(n) > depth) begin
            return depth;
        end
        return 32'(n);
    endfunction

endpackage

// File: rtl/mem_boot_loader_if.sv
// Byte-stream handshake and memory-bus control lines of the boot loader.
// The 32-bit data bus is bidirectional and stays a plain port on the top.
interface mem_boot_loader_if #(
    parameter int unsigned ADDR_W = 7
);
    logic [7:0]        BYTE_IN;
    logic              BYTE_VALID;
    logic              BYTE_READY;
    logic              CS;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;

    // Loader side
    modport master (
        input  BYTE_IN,
        input  BYTE_VALID,
        output BYTE_READY,
        output CS,
        output WE,
        output ADDR
    );

    // Host link / memory side
    modport slave (
        output BYTE_IN,
        output BYTE_VALID,
        input  BYTE_READY,
        input  CS,
        input  WE,
        input  ADDR
    );
endinterface

// File: rtl/mem_boot_loader_word_packer.sv
// Packs accepted stream bytes into 32-bit words; strobes word_valid_c on the
// byte that completes a word, with the completed word on word_c that cycle.
module boot_word_packer
    import boot_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [BYTE_W-1:0]   byte_in,
    output logic                word_valid_c,
    output logic [WORD_W-1:0]   word_c
);

    logic [1:0]  cnt_q;
    logic [23:0] sr_q;

    // Byte shift register and position counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            sr_q  <= 24'd0;
        end else if (clr) begin
            cnt_q <= 2'd0;
        end else if (en) begin
            cnt_q <= cnt_q + 2'd1;
            sr_q  <= {sr_q[15:0], byte_in};
        end
    end

    // Word completes on the fourth byte
    always_comb begin
        word_valid_c = en && (cnt_q == 2'd3);
        word_c       = MSB_FIRST ? {sr_q, byte_in}
                                 : {byte_in, sr_q[7:0], sr_q[15:8], sr_q[23:16]};
    end

endmodule

// File: rtl/mem_boot_loader.sv
// Memory boot loader: receives a length-prefixed byte stream, packs it into
// words and writes them to RAM at BASE_ADDR+i while holding the CPU in reset.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing XOR checksum byte
// that decides between DONE and ERR.
module mem_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    mem_boot_loader_if.master bus,
    inout  wire [WORD_W-1:0]  Mem_Bus,
    output logic              CPU_RST,
    output logic              DONE,
    output logic              ERR
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              start_load;
    logic              accept;
    logic              word_valid_c;
    logic [WORD_W-1:0] word_c;
`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              err_q, err_d;
`endif

    assign accept = ready_q && bus.BYTE_VALID;

    boot_word_packer u_packer (
        .clk          (CLK),
        .rst_n        (RST_N),
        .clr          (start_load),
        .en           (accept && (state_q == ST_COLLECT)),
        .byte_in      (bus.BYTE_IN),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            words_q    <= '0;
            word_cnt_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            word_cnt_q <= word_cnt_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next state; outputs follow the state being entered so they are valid
    // for the whole cycle spent in it
    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        word_cnt_d = word_cnt_q;
        data_d     = data_q;
        addr_d     = addr_q;
        start_load = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            ST_IDLE, ST_FIN, ST_FAIL: begin
                if (START) begin
                    state_d    = ST_LEN;
                    start_load = 1'b1;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    words_d = CNT_W'(words_from_len(bus.BYTE_IN, DEPTH));
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ bus.BYTE_IN;
`endif
                    if (word_valid_c) begin
                        data_d  = word_c;
                        addr_d  = ADDR_W'(BASE_ADDR + 32'(word_cnt_q));
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
                if (32'(word_cnt_q) + 32'd1 < 32'(words_q)) begin
                    state_d = ST_COLLECT;
                end else begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_FIN;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d = (bus.BYTE_IN == csum_q) ? ST_FIN : ST_FAIL;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (start_load) begin
            word_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
            csum_d     = '0;
`endif
        end

        ready_d   = (state_d == ST_LEN) || (state_d == ST_COLLECT) || (state_d == ST_CHK);
        we_d      = (state_d == ST_WRITE);
        cpu_rst_d = !((state_d == ST_IDLE) || (state_d == ST_FIN));
        done_d    = (state_d == ST_FIN);
`ifdef BOOT_CHECKSUM_EN
        err_d     = (state_d == ST_FAIL);
`endif
    end

    // Bus drivers: data is driven only during the single write cycle
    assign bus.BYTE_READY = ready_q;
    assign bus.CS         = we_q;
    assign bus.WE         = we_q;
    assign bus.ADDR       = addr_q;
    assign Mem_Bus        = we_q ? data_q : {WORD_W{1'bz}};
    assign CPU_RST        = cpu_rst_q;
    assign DONE           = done_q;
`ifdef BOOT_CHECKSUM_EN
    assign ERR            = err_q;
`else
    assign ERR            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: two instances (BASE_ADDR 0 and 100) see the same
// stream; expected writes are queued per instance and popped at each write.
module tb_mem_boot_loader;
    import boot_loader_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N;
    logic        START;
    wire  [31:0] bus_a, bus_b;
    logic        cpu_rst_a, done_a, err_a, cpu_rst_b, done_b, err_b;

    mem_boot_loader_if #(.ADDR_W(7)) if_a ();
    mem_boot_loader_if #(.ADDR_W(7)) if_b ();

    mem_boot_loader #(.ADDR_W(7), .DEPTH(128), .BASE_ADDR(0)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .START(START), .bus(if_a), .Mem_Bus(bus_a),
        .CPU_RST(cpu_rst_a), .DONE(done_a), .ERR(err_a));

    mem_boot_loader #(.ADDR_W(7), .DEPTH(128), .BASE_ADDR(100)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .START(START), .bus(if_b), .Mem_Bus(bus_b),
        .CPU_RST(cpu_rst_b), .DONE(done_b), .ERR(err_b));

    int checks = 0;
    int failures = 0;
    logic [38:0] exp_a[$];
    logic [38:0] exp_b[$];
    logic [31:0] ram_a [128];
    logic [31:0] ram_b [128];
    int wr_a = 0;
    int wr_b = 0;
    logic [7:0] img [512];

    // RAM models sample on the falling edge; each write is checked against the queue
    initial begin
        logic [38:0] e;
        forever begin
            @(negedge CLK);
            if (if_a.WE === 1'b1) begin
                ram_a[if_a.ADDR] = bus_a;
                wr_a++;
                checks++;
                if (exp_a.size() == 0) begin
                    failures++;
                    $display("FAIL wr_a_unexpected actual addr=%0d data=%h required none", if_a.ADDR, bus_a);
                end else begin
                    e = exp_a.pop_front();
                    if ({if_a.ADDR, bus_a} !== e) begin
                        failures++;
                        $display("FAIL wr_a actual=%0d:%h required=%0d:%h", if_a.ADDR, bus_a, e[38:32], e[31:0]);
                    end
                end
                checks++;
                if (if_a.BYTE_READY !== 1'b0 || if_a.CS !== 1'b1) begin
                    failures++;
                    $display("FAIL write_ctl_a actual ready=%b cs=%b required ready=0 cs=1", if_a.BYTE_READY, if_a.CS);
                end
            end
            if (if_b.WE === 1'b1) begin
                ram_b[if_b.ADDR] = bus_b;
                wr_b++;
                checks++;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL wr_b_unexpected actual addr=%0d data=%h required none", if_b.ADDR, bus_b);
                end else begin
                    e = exp_b.pop_front();
                    if ({if_b.ADDR, bus_b} !== e) begin
                        failures++;
                        $display("FAIL wr_b actual=%0d:%h required=%0d:%h", if_b.ADDR, bus_b, e[38:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic set_in(input logic [7:0] b, input logic v);
        if_a.BYTE_IN = b;  if_b.BYTE_IN = b;
        if_a.BYTE_VALID = v; if_b.BYTE_VALID = v;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Offer one byte, optionally after idle cycles, and hold it until accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) begin
            set_in(8'h00, 1'b0);
            tick();
        end
        set_in(b, 1'b1);
        while (if_a.BYTE_READY !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end else begin
            tick();
        end
        set_in(8'h00, 1'b0);
    endtask

    // Queue expected writes, stream an image, then check the end state
    task automatic load(input logic [7:0] hdr, input int nw, input int gap,
                        input bit poke, input bit bad_sum, input bit do_start);
        logic [7:0] x;
        bit exp_err;
        int n;
        x = 8'h00;
        n = 0;
        wr_a = 0;
        wr_b = 0;
        if (do_start) pulse_start();
        for (int i = 0; i < nw; i++) begin
            exp_a.push_back({7'(i), img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]});
            exp_b.push_back({7'(100 + i), img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]});
        end
        send_byte(hdr, gap);
        for (int j = 0; j < 4*nw; j++) begin
            send_byte(img[j], gap);
            x = x ^ img[j];
            if (poke && (j == 1 || j == 4)) pulse_start();
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(bad_sum ? (x ^ 8'h01) : x, gap);
        exp_err = bad_sum;
`else
        exp_err = 1'b0;
`endif
        while (done_a !== 1'b1 && err_a !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (done_a !== !exp_err || err_a !== exp_err) begin
            failures++;
            $display("FAIL end_flags actual done=%b err=%b required done=%b err=%b", done_a, err_a, !exp_err, exp_err);
        end
        checks++;
        if (cpu_rst_a !== exp_err) begin
            failures++;
            $display("FAIL end_cpu_rst actual=%b required=%b", cpu_rst_a, exp_err);
        end
        checks++;
        if (done_b !== !exp_err || cpu_rst_b !== exp_err) begin
            failures++;
            $display("FAIL end_b actual done=%b cpu_rst=%b required done=%b cpu_rst=%b", done_b, cpu_rst_b, !exp_err, exp_err);
        end
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0 || wr_a != nw || wr_b != nw) begin
            failures++;
            $display("FAIL write_count actual a=%0d b=%0d left=%0d/%0d required=%0d", wr_a, wr_b, exp_a.size(), exp_b.size(), nw);
        end
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic set_img_fixed();
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        img[4] = 8'h55; img[5] = 8'h66; img[6] = 8'h77; img[7] = 8'h88;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b0;
        set_in(8'h00, 1'b0);
        #22;
        checks++;
        if (if_a.CS !== 1'b0 || if_a.WE !== 1'b0 || if_a.ADDR !== 7'd0 || if_a.BYTE_READY !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus actual cs=%b we=%b addr=%0d ready=%b required 0 0 0 0", if_a.CS, if_a.WE, if_a.ADDR, if_a.BYTE_READY);
        end
        checks++;
        if (cpu_rst_a !== 1'b1 || done_a !== 1'b0 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags actual cpu_rst=%b done=%b err=%b required 1 0 0", cpu_rst_a, done_a, err_a);
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();
        checks++;
        if (cpu_rst_a !== 1'b0 || if_a.BYTE_READY !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset actual cpu_rst=%b ready=%b required 0 0", cpu_rst_a, if_a.BYTE_READY);
        end
    endtask

    task automatic test_basic();
        set_img_fixed();
        pulse_start();
        checks++;
        if (cpu_rst_a !== 1'b1 || if_a.BYTE_READY !== 1'b1) begin
            failures++;
            $display("FAIL start_len actual cpu_rst=%b ready=%b required 1 1", cpu_rst_a, if_a.BYTE_READY);
        end
        load(8'h02, 2, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ram_a[0] !== 32'h11223344 || ram_a[1] !== 32'h55667788) begin
            failures++;
            $display("FAIL ram_basic actual=%h %h required=11223344 55667788", ram_a[0], ram_a[1]);
        end
    endtask

    task automatic test_full_image();
        for (int i = 0; i < 512; i++) img[i] = 8'($urandom);
        load(8'h00, 128, 0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ram_b[0] !== {img[112], img[113], img[114], img[115]}) begin
            failures++;
            $display("FAIL addr_wrap actual=%h required=%h", ram_b[0], {img[112], img[113], img[114], img[115]});
        end
        load(8'd200, 128, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        set_img_fixed();
        load(8'h02, 2, 1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ram_a[0] !== 32'h11223344 || ram_a[1] !== 32'h55667788) begin
            failures++;
            $display("FAIL ram_stall actual=%h %h required=11223344 55667788", ram_a[0], ram_a[1]);
        end
    endtask

    task automatic test_reset_mid_load();
        img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3; img[3] = 8'hD4;
        img[4] = 8'hE5; img[5] = 8'hF6;
        ram_a[1] = 32'h5A5A5A5A;
        wr_a = 0;
        pulse_start();
        exp_a.push_back({7'd0, 32'hA1B2C3D4});
        exp_b.push_back({7'd100, 32'hA1B2C3D4});
        send_byte(8'h02, 0);
        for (int j = 0; j < 6; j++) send_byte(img[j], 0);
        set_in(8'h77, 1'b1);
        RST_N = 1'b0;
        #1;
        checks++;
        if (if_a.CS !== 1'b0 || if_a.WE !== 1'b0 || if_a.BYTE_READY !== 1'b0 || cpu_rst_a !== 1'b1) begin
            failures++;
            $display("FAIL async_reset actual cs=%b we=%b ready=%b cpu_rst=%b required 0 0 0 1", if_a.CS, if_a.WE, if_a.BYTE_READY, cpu_rst_a);
        end
        set_in(8'h00, 1'b0);
        tick();
        RST_N = 1'b1;
        tick();
        checks++;
        if (cpu_rst_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL after_reset actual cpu_rst=%b done=%b required 0 0", cpu_rst_a, done_a);
        end
        checks++;
        if (wr_a != 1 || ram_a[1] !== 32'h5A5A5A5A || ram_a[0] !== 32'hA1B2C3D4 || exp_a.size() != 0) begin
            failures++;
            $display("FAIL partial_image actual wr=%0d ram1=%h ram0=%h required 1 5a5a5a5a a1b2c3d4", wr_a, ram_a[1], ram_a[0]);
        end
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic test_checksum();
`ifdef BOOT_CHECKSUM_EN
        img[0] = 8'hDE; img[1] = 8'hAD; img[2] = 8'hBE; img[3] = 8'hEF;
        load(8'h01, 1, 0, 1'b0, 1'b0, 1'b1);
        load(8'h01, 1, 0, 1'b0, 1'b1, 1'b1);
        pulse_start();
        checks++;
        if (err_a !== 1'b0 || done_a !== 1'b0 || if_a.BYTE_READY !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear actual err=%b done=%b ready=%b required 0 0 1", err_a, done_a, if_a.BYTE_READY);
        end
        load(8'h01, 1, 0, 1'b0, 1'b0, 1'b0);
`else
        img[0] = 8'hDE; img[1] = 8'hAD; img[2] = 8'hBE; img[3] = 8'hEF;
        load(8'h01, 1, 0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (err_a !== 1'b0) begin
            failures++;
            $display("FAIL err_tied actual=%b required=0", err_a);
        end
`endif
    endtask

    task automatic test_start_ignored();
        set_img_fixed();
        load(8'h02, 2, 0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (ram_a[0] !== 32'h11223344 || ram_a[1] !== 32'h55667788) begin
            failures++;
            $display("FAIL ram_poke actual=%h %h required=11223344 55667788", ram_a[0], ram_a[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_image();
        test_stall();
        test_reset_mid_load();
        test_checksum();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
